// File: rtl/gf_pow.sv
// GF(2^WIDTH) exponentiation, base^exp, by left-to-right square-and-multiply with one exponent bit per clock.
// Optional macro GF_POW_INV_EN adds inv_i, which forces exponent 2^WIDTH-2 so the result is the multiplicative inverse.
module gf_pow #(
  parameter int                 WIDTH = 8,
  parameter logic [WIDTH-1:0]   POLY  = 8'h1B,
  parameter int                 EXP_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [WIDTH-1:0]  base_i,
  input  logic [EXP_W-1:0]  exp_i,
`ifdef GF_POW_INV_EN
  input  logic              inv_i,
`endif
  output logic              valid_o,
  input  logic              ready_i,
  output logic [WIDTH-1:0]  result_o,
  output logic              busy_o
);

  localparam int CNT_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
`ifdef GF_POW_INV_EN
  localparam logic [EXP_W-1:0] INV_EXP = EXP_W'((2 ** WIDTH) - 2);
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]  base_q, base_d;
  logic [EXP_W-1:0]  exp_q, exp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [WIDTH-1:0]  sq, sq_mul;

  // Multiply by x, folding the carried-out x^WIDTH term back in via POLY.
  function automatic logic [WIDTH-1:0] xtime(input logic [WIDTH-1:0] a);
    xtime = {a[WIDTH-2:0], 1'b0} ^ (a[WIDTH-1] ? POLY : '0);
  endfunction

  function automatic logic [WIDTH-1:0] gf_mul(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < WIDTH; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    gf_mul = p;
  endfunction

  assign sq     = gf_mul(acc_q, acc_q);
  assign sq_mul = gf_mul(sq, base_q);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    base_d  = base_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (valid_i) begin
          base_d  = base_i;
          exp_d   = exp_i;
`ifdef GF_POW_INV_EN
          if (inv_i) exp_d = INV_EXP;
`endif
          acc_d   = WIDTH'(1);
          cnt_d   = CNT_W'(EXP_W - 1);
          state_d = RUN;
        end
      end
      RUN: begin
        // Every exponent bit is walked, leading zeros included, so timing is data independent.
        acc_d = exp_q[cnt_q] ? sq_mul : sq;
        if (cnt_q == '0) begin
          res_d   = acc_d;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      acc_q   <= '0;
      base_q  <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      base_q  <= base_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  // result_o comes from its own register so it keeps the last answer through IDLE and RUN.
  assign result_o = res_q;
  assign ready_o  = (state_q == IDLE);
  assign valid_o  = (state_q == DONE);
  assign busy_o   = (state_q == RUN) || (state_q == DONE);

endmodule

// File: tb/tb_gf_pow.sv
// Directed, table-driven bench for gf_pow over the AES field plus hand-written backpressure and reset-abort sequences.
module tb_gf_pow;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] base_i;
  logic [7:0] exp_i;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] result_o;
  logic       busy_o;
`ifdef GF_POW_INV_EN
  logic       inv_i;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  gf_pow dut (
    .clk_i    (clk),
    .rst_ni   (rst_ni),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .base_i   (base_i),
    .exp_i    (exp_i),
`ifdef GF_POW_INV_EN
    .inv_i    (inv_i),
`endif
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  typedef struct {
    logic [7:0] base;
    logic [7:0] ex;
    logic       inv;
    logic [7:0] res;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [7:0] b, input logic [7:0] e, input logic inv,
                         input logic [7:0] r);
    vec_t v;
    v.base = b;
    v.ex   = e;
    v.inv  = inv;
    v.res  = r;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Issues one request and returns the result plus the edge count, counting the
  // accepting edge as edge 1, at which valid_o is first seen high.
  task automatic run_req(input logic [7:0] b, input logic [7:0] e, input logic inv,
                         output logic [7:0] r, output int lat);
    @(negedge clk);
    valid_i = 1'b1;
    base_i  = b;
    exp_i   = e;
`ifdef GF_POW_INV_EN
    inv_i   = inv;
`else
    if (inv) $display("note: inv request issued without inversion support");
`endif
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    base_i  = 8'hA5;
    exp_i   = 8'h5A;
`ifdef GF_POW_INV_EN
    inv_i   = 1'b0;
`endif
    lat = 1;
    while (!valid_o && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!valid_o) check("timeout_valid_o", 32'd0, 32'd1);
    r = result_o;
  endtask

  task automatic handshake();
    @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
  endtask

  initial begin
    logic [7:0] r;
    int         lat;

    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    base_i  = 8'h00;
    exp_i   = 8'h00;
`ifdef GF_POW_INV_EN
    inv_i   = 1'b0;
`endif

    add_vec(8'h02, 8'd8,   1'b0, 8'h1B);
    add_vec(8'h02, 8'd2,   1'b0, 8'h04);
    add_vec(8'h00, 8'd0,   1'b0, 8'h01);
    add_vec(8'h00, 8'd5,   1'b0, 8'h00);
    add_vec(8'h03, 8'd255, 1'b0, 8'h01);
    add_vec(8'h53, 8'd254, 1'b0, 8'hCA);
    add_vec(8'h02, 8'd7,   1'b0, 8'h80);
    add_vec(8'h02, 8'd9,   1'b0, 8'h36);
    add_vec(8'h03, 8'd2,   1'b0, 8'h05);
    add_vec(8'hFF, 8'd0,   1'b0, 8'h01);
    add_vec(8'h03, 8'd1,   1'b0, 8'h03);
`ifdef GF_POW_INV_EN
    add_vec(8'h53, 8'h00,  1'b1, 8'hCA);
    add_vec(8'h00, 8'h00,  1'b1, 8'h00);
`endif

    // Reset state, both during and after reset.
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_o",  32'(ready_o),  32'd1);
    check("rst_valid_o",  32'(valid_o),  32'd0);
    check("rst_busy_o",   32'(busy_o),   32'd0);
    check("rst_result_o", 32'(result_o), 32'h00);
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_ready_o",  32'(ready_o),  32'd1);
    check("idle_valid_o",  32'(valid_o),  32'd0);
    check("idle_busy_o",   32'(busy_o),   32'd0);
    check("idle_result_o", 32'(result_o), 32'h00);

    // Busy while running.
    @(negedge clk);
    valid_i = 1'b1; base_i = 8'h02; exp_i = 8'd8;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    check("run_busy_o",  32'(busy_o),  32'd1);
    check("run_ready_o", 32'(ready_o), 32'd0);
    check("run_valid_o", 32'(valid_o), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("first_result", 32'(result_o), 32'h1B);
    handshake();

    foreach (vecs[i]) begin
      run_req(vecs[i].base, vecs[i].ex, vecs[i].inv, r, lat);
      check($sformatf("vec%0d_result", i), 32'(r), 32'(vecs[i].res));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd9);
      handshake();
      check($sformatf("vec%0d_ready_after", i), 32'(ready_o), 32'd1);
      check($sformatf("vec%0d_hold_result", i), 32'(result_o), 32'(vecs[i].res));
    end

    // Backpressure in DONE, with a competing request that must be ignored.
    run_req(8'h02, 8'd2, 1'b0, r, lat);
    @(negedge clk);
    valid_i = 1'b1; base_i = 8'h03; exp_i = 8'd1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp%0d_valid_o", k), 32'(valid_o), 32'd1);
      check($sformatf("bp%0d_result_o", k), 32'(result_o), 32'h04);
      check($sformatf("bp%0d_ready_o", k), 32'(ready_o), 32'd0);
    end
    @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    valid_i = 1'b0;
    check("bp_release_ready_o", 32'(ready_o), 32'd1);
    check("bp_release_valid_o", 32'(valid_o), 32'd0);
    check("bp_release_busy_o",  32'(busy_o),  32'd0);
    check("bp_release_result",  32'(result_o), 32'h04);

    // Reset asserted mid-RUN aborts immediately.
    @(negedge clk);
    valid_i = 1'b1; base_i = 8'h02; exp_i = 8'd9;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b0;
    #1;
    check("abort_ready_o",  32'(ready_o),  32'd1);
    check("abort_valid_o",  32'(valid_o),  32'd0);
    check("abort_busy_o",   32'(busy_o),   32'd0);
    check("abort_result_o", 32'(result_o), 32'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("abort_no_result", 32'(valid_o), 32'd0);
    run_req(8'h02, 8'd8, 1'b0, r, lat);
    check("post_abort_result",  32'(r),   32'h1B);
    check("post_abort_latency", 32'(lat), 32'd9);
    handshake();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
